// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one val/rdy stream engine between two requesters.
// An in-order tag FIFO routes each engine response back to the requester that issued the beat.
module stream_rr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         req0_i_val,
  output logic                         req0_i_rdy,
  input  logic [DATA_W-1:0]            req0_i_data,
  output logic                         req0_o_val,
  input  logic                         req0_o_rdy,
  output logic [DATA_W-1:0]            req0_o_data,

  input  logic                         req1_i_val,
  output logic                         req1_i_rdy,
  input  logic [DATA_W-1:0]            req1_i_data,
  output logic                         req1_o_val,
  input  logic                         req1_o_rdy,
  output logic [DATA_W-1:0]            req1_o_data,

  output logic                         eng_i_val,
  input  logic                         eng_i_rdy,
  output logic [DATA_W-1:0]            eng_i_data,
  input  logic                         eng_o_val,
  output logic                         eng_o_rdy,
  input  logic [DATA_W-1:0]            eng_o_data,

  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         orphan_err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 last_grant;

  logic full;
  logic empty;
  logic grant1;
  logic grant0;
  logic push;
  logic pop;
  logic head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // req1 wins only when it is alone or when req0 had the last issue.
  assign grant1 = req1_i_val & (~req0_i_val | ~last_grant);
  assign grant0 = req0_i_val & ~grant1;

  assign eng_i_val  = (req0_i_val | req1_i_val) & ~full;
  assign eng_i_data = grant1 ? req1_i_data : req0_i_data;
  assign req0_i_rdy = grant0 & eng_i_rdy & ~full;
  assign req1_i_rdy = grant1 & eng_i_rdy & ~full;
  assign push       = eng_i_val & eng_i_rdy;

  assign head        = tag_mem[rd_ptr];
  assign req0_o_val  = eng_o_val & ~empty & ~head;
  assign req1_o_val  = eng_o_val & ~empty & head;
  assign req0_o_data = eng_o_data;
  assign req1_o_data = eng_o_data;
  assign eng_o_rdy   = ~empty & (head ? req1_o_rdy : req0_o_rdy);
  assign pop         = eng_o_val & eng_o_rdy;

  assign outstanding = count;

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      orphan_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        last_grant <= grant1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (eng_o_val && empty) begin
        orphan_err <= 1'b1;
      end
    end
  end

endmodule
